deserializer: RTL
=================

# deserializer

Receive side of the serial link driven by our serializers. It samples an externally clocked serial stream (`ser_clock`/`ser_data`, framed by `ser_frame`) in the system `clock` domain. It assembles LSB-first words and presents each word on a parallel output with a valid/ready handshake and a one-word holding register. It sits between the serial pins and any parallel consumer, such as the ALU operand path.

## Interface
- `WIDTH`, default 8: word width in bits; minimum 2.
- `SYNC_STAGES`, default 2: synchronizer depth for `ser_clock`, `ser_data` and `ser_frame`; minimum 2.

Ports (one clock; reset is synchronous and active-high):
- `clock`  in  1: system clock, rising edge.
- `reset`  in  1: synchronous, active-high reset.
- `ser_clock`  in  1: serial bit clock, asynchronous to `clock`; transmitter changes data on its rising edge.
- `ser_data`  in  1: serial data, LSB first.
- `ser_frame`  in  1: high while a word is being transmitted (transmitter's inverted `empty`).
- `par_data`  out  WIDTH: received word, stable while `par_valid`.
- `par_valid`  out  1: word available.
- `par_ready`  in  1: consumer accepts the word when `par_valid && par_ready` on a rising `clock` edge.
- `overrun`  out  1: one-cycle pulse; a completed word was dropped.
- `frame_error`  out  1: one-cycle pulse; `ser_frame` fell before the word was complete.
- `busy`  out  1: high in `SHIFT` (and `PARITY`).

## Operation
- All three serial inputs pass through `SYNC_STAGES` flops. One extra flop on synchronized `ser_clock` gives falling-edge detect `fall = prev & ~cur`. Data is sampled only on `fall`.
- States:
  - `IDLE`: wait for synchronized `ser_frame` = 1, then go to `SHIFT`. Clear the bit counter and the shift register.
  - `SHIFT`: on each `fall`, shift the synchronized `ser_data` in at the MSB end, right-shift, and increment the counter.
    - On the `WIDTH`-th sample, the word is complete. Go to `DONE`, or to `PARITY` when enabled.
    - If `ser_frame` = 0 in `SHIFT` with no `fall` that cycle, pulse `frame_error`, discard the partial word, and go to `IDLE`.
  - `DONE`: wait for `ser_frame` = 0, then go to `IDLE`. Extra `fall` edges here are ignored, with no error.
- Bit counter width is `$clog2(WIDTH+1)`. It never wraps, because it saturates at `WIDTH` via the state change.
- Word completion, in the cycle the word completes:
  - If `par_valid` = 0, or `par_ready` = 1 in that same cycle: load `par_data` and set `par_valid` = 1. A simultaneous accept and load keeps `par_valid` high with the new word.
  - Otherwise keep the old word and pulse `overrun`. The new word is dropped.
- `par_valid` clears on accept when no word completes in the same cycle.
- Reset values:
  - state `IDLE`.
  - `par_data` = 0, `par_valid` = 0, `overrun` = 0, `frame_error` = 0, `busy` = 0.
  - counter and shift register = 0.
  - synchronizer flops = 0.
- Reset mid-word discards all progress. After reset, a `ser_frame` already high is treated as a new frame start. The bench must not rely on this; it deasserts the frame first.

## Timing
- Input to internal: a `ser_clock` falling edge at the pin is detected `SYNC_STAGES`+1 `clock` cycles later, worst case.
- Last-bit edge to `par_valid` high: `SYNC_STAGES`+2 cycles. For default parameters, last `fall` detected in cycle N gives `par_valid` in cycle N+1.
- Constraint: `ser_clock` high and low phases are each ≥ `SYNC_STAGES`+2 `clock` periods.
- Constraint: `ser_data` is stable from its change on the `ser_clock` rise through the detected fall.
- `ser_frame` must rise at least one `clock` period before the first `ser_clock` fall, and fall no earlier than the last fall edge.
- `overrun` and `frame_error` are registered, one cycle wide, and asserted in the cycle after the event.
- `par_ready` has no combinational path to any output.

## Configuration
- `DESERIALIZER_PARITY_EN` defined:
  - After `WIDTH` data bits, the block samples one extra bit in state `PARITY`.
  - Even parity over data plus parity bit is required.
  - Adds output `parity_error` (1 bit, reset 0). It pulses for one cycle on mismatch; the word is still delivered.
  - Frame loss in `PARITY` counts as `frame_error`, and the word is discarded.
- `DESERIALIZER_PARITY_EN` not defined: no `PARITY` state and no `parity_error` port. `SHIFT` goes directly to `DONE`.

## Test plan
- Reset, then send frame 0xA5 (bits 1,0,1,0,0,1,0,1) with `par_ready` = 1 → `par_valid` pulses one cycle with `par_data` = 0xA5, exactly `SYNC_STAGES`+2 cycles after the last fall; no error pulses.
- Send 0x3C with `par_ready` = 0, then 0xFF → `par_data` stays 0x3C and `par_valid` stays 1; `overrun` pulses once at 0xFF completion. Raising `par_ready` accepts 0x3C, and `par_valid` drops.
- Hold `par_valid` = 1 with 0x11 and assert `par_ready` in the exact cycle 0x22 completes → `par_data` = 0x22, `par_valid` stays 1, no `overrun`.
- Drop `ser_frame` after 5 bits → `frame_error` pulse, `busy` low, no `par_valid`. The next full frame 0x81 is received correctly.
- Assert `reset` after 4 bits, release, and send 0x5A → all outputs at reset values during reset; `par_data` = 0x5A afterwards.
- With `DESERIALIZER_PARITY_EN`: send 0x07 with parity bit 1 → no `parity_error`. Send 0x07 with parity bit 0 → `parity_error` pulses, and `par_data` = 0x07 is still delivered.

Source files
------------

// File: rtl/deserializer.sv
// deserializer: receive side of the serial link.
// Synchronizes an externally clocked serial stream (ser_clock/ser_data framed
// by ser_frame) into the clock domain, samples data on falling ser_clock
// edges, assembles LSB-first words and hands them out through a one-word
// valid/ready holding register.
// Optional feature: define DESERIALIZER_PARITY_EN to receive one extra even
// parity bit per word and expose the parity_error output.
module deserializer #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ser_clock,
    input  logic             ser_data,
    input  logic             ser_frame,
    output logic [WIDTH-1:0] par_data,
    output logic             par_valid,
    input  logic             par_ready,
    output logic             overrun,
    output logic             frame_error,
`ifdef DESERIALIZER_PARITY_EN
    output logic             parity_error,
`endif
    output logic             busy
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_DONE
`ifdef DESERIALIZER_PARITY_EN
        , S_PARITY
`endif
    } state_t;

    logic [SYNC_STAGES-1:0] sclk_sync_q;
    logic [SYNC_STAGES-1:0] sdat_sync_q;
    logic [SYNC_STAGES-1:0] sfrm_sync_q;
    logic                   sclk_prev_q;
    logic                   sclk_s;
    logic                   sdat_s;
    logic                   sfrm_s;
    logic                   fall;

    state_t                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [WIDTH-1:0]       shift_q, shift_d;
    logic                   word_done;
    logic [WIDTH-1:0]       word_val;
    logic                   ferr_d;

    logic [WIDTH-1:0]       par_data_q, par_data_d;
    logic                   par_valid_q, par_valid_d;
    logic                   overrun_q, overrun_d;
    logic                   frame_error_q;
`ifdef DESERIALIZER_PARITY_EN
    logic                   perr_d;
    logic                   parity_error_q;
`endif

    assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
    assign sdat_s = sdat_sync_q[SYNC_STAGES-1];
    assign sfrm_s = sfrm_sync_q[SYNC_STAGES-1];
    // Data is stable around the falling edge since the transmitter changes it on the rise.
    assign fall   = sclk_prev_q & ~sclk_s;

    // Synchronizer chains for the three serial pins plus the edge-detect flop.
    always_ff @(posedge clock) begin
        if (reset) begin
            sclk_sync_q <= '0;
            sdat_sync_q <= '0;
            sfrm_sync_q <= '0;
            sclk_prev_q <= 1'b0;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], ser_clock};
            sdat_sync_q <= {sdat_sync_q[SYNC_STAGES-2:0], ser_data};
            sfrm_sync_q <= {sfrm_sync_q[SYNC_STAGES-2:0], ser_frame};
            sclk_prev_q <= sclk_s;
        end
    end

    // Receive FSM: framing, bit counting and word assembly.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        shift_d   = shift_q;
        word_done = 1'b0;
        word_val  = shift_q;
        ferr_d    = 1'b0;
`ifdef DESERIALIZER_PARITY_EN
        perr_d    = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                cnt_d   = '0;
                shift_d = '0;
                if (sfrm_s) begin
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (fall) begin
                    shift_d = {sdat_s, shift_q[WIDTH-1:1]};
                    cnt_d   = cnt_q + 1'b1;
                    // Leaving SHIFT on the last bit keeps the counter from wrapping.
                    if (cnt_q == CW'(WIDTH - 1)) begin
`ifdef DESERIALIZER_PARITY_EN
                        state_d = S_PARITY;
`else
                        word_done = 1'b1;
                        word_val  = shift_d;
                        state_d   = S_DONE;
`endif
                    end
                end else if (!sfrm_s) begin
                    ferr_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
`ifdef DESERIALIZER_PARITY_EN
            S_PARITY: begin
                if (fall) begin
                    // Even parity: XOR of data and parity bit must be zero.
                    perr_d    = ^{shift_q, sdat_s};
                    word_done = 1'b1;
                    word_val  = shift_q;
                    state_d   = S_DONE;
                end else if (!sfrm_s) begin
                    ferr_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
`endif
            S_DONE: begin
                // Stray falls after the word are ignored; only frame end matters.
                if (!sfrm_s) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Holding register: load when empty or emptied this cycle, else drop and flag overrun.
    always_comb begin
        par_data_d  = par_data_q;
        par_valid_d = par_valid_q;
        overrun_d   = 1'b0;
        if (word_done) begin
            if (!par_valid_q || par_ready) begin
                par_data_d  = word_val;
                par_valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (par_valid_q && par_ready) begin
            par_valid_d = 1'b0;
        end
    end

    // State, datapath and registered output pulses.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            shift_q       <= '0;
            par_data_q    <= '0;
            par_valid_q   <= 1'b0;
            overrun_q     <= 1'b0;
            frame_error_q <= 1'b0;
`ifdef DESERIALIZER_PARITY_EN
            parity_error_q <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            shift_q       <= shift_d;
            par_data_q    <= par_data_d;
            par_valid_q   <= par_valid_d;
            overrun_q     <= overrun_d;
            frame_error_q <= ferr_d;
`ifdef DESERIALIZER_PARITY_EN
            parity_error_q <= perr_d;
`endif
        end
    end

    assign par_data    = par_data_q;
    assign par_valid   = par_valid_q;
    assign overrun     = overrun_q;
    assign frame_error = frame_error_q;
`ifdef DESERIALIZER_PARITY_EN
    assign parity_error = parity_error_q;
    assign busy         = (state_q == S_SHIFT) || (state_q == S_PARITY);
`else
    assign busy         = (state_q == S_SHIFT);
`endif

endmodule
